// File: rtl/fifo_in_ctrl_pkg.sv
// fifo_in_ctrl_pkg: shared widths and FSM state encoding for the input FIFO controller
package fifo_in_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 3;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);
  typedef enum logic [2:0] {
    INIT,
    NO_OP,
    WRITE,
    WR_ERROR,
    READ,
    RD_ERROR
  } state_t;
endpackage

// File: rtl/fifo_in_ctrl_if.sv
// fifo_in_ctrl_if: request, register-file and status signals of the input FIFO controller
interface fifo_in_ctrl_if;
  import fifo_in_ctrl_pkg::*;
  logic wr_en;
  logic rd_en;
  logic [DATA_W-1:0] rd_data;
  logic we;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] d_out;
  logic full;
  logic empty;
  logic wr_ack;
  logic wr_err;
  logic rd_ack;
  logic rd_err;
  logic [ADDR_W:0] data_count;
  modport master (
    output wr_en, rd_en, rd_data,
    input we, wr_addr, rd_addr, d_out, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count
  );
  modport slave (
    input wr_en, rd_en, rd_data,
    output we, wr_addr, rd_addr, d_out, full, empty, wr_ack, wr_err, rd_ack, rd_err, data_count
  );
endinterface

// File: rtl/fifo_ptr_cnt.sv
// fifo_ptr_cnt: wrap-around pointer counter with increment enable and async active-low clear
module fifo_ptr_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) q <= '0;
    else if (inc) q <= q + 1'b1;
endmodule

// File: rtl/fifo_in_ctrl.sv
// fifo_in_ctrl: push/pop control, pointers, occupancy and Moore ack/err status for the input FIFO
module fifo_in_ctrl
  import fifo_in_ctrl_pkg::*;
(
  input logic clk,
  input logic reset_n,
  fifo_in_ctrl_if.slave bus
);
  state_t state, next_state;
  logic [ADDR_W:0] count;
  logic push, pop;
  assign bus.full = count == DEPTH_CNT;
  assign bus.empty = count == '0;
  // gated by reset_n so no write strobe leaks out while reset is held
  assign push = reset_n & bus.wr_en & ~bus.rd_en & ~bus.full;
  assign pop = reset_n & bus.rd_en & ~bus.wr_en & ~bus.empty;
  assign bus.we = push;
  assign bus.data_count = count;
  assign bus.wr_ack = state == WRITE;
  assign bus.wr_err = state == WR_ERROR;
  assign bus.rd_ack = state == READ;
  assign bus.rd_err = state == RD_ERROR;
  fifo_ptr_cnt #(.W(ADDR_W)) u_tail (.clk(clk), .reset_n(reset_n), .inc(push), .q(bus.wr_addr));
  fifo_ptr_cnt #(.W(ADDR_W)) u_head (.clk(clk), .reset_n(reset_n), .inc(pop), .q(bus.rd_addr));
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= INIT;
      count <= '0;
      bus.d_out <= '0;
    end else begin
      state <= next_state;
      count <= push ? count + 1'b1 : pop ? count - 1'b1 : count;
      if (pop) bus.d_out <= bus.rd_data;
    end
  always_comb begin
    next_state = NO_OP;
    if (bus.wr_en && !bus.rd_en) next_state = bus.full ? WR_ERROR : WRITE;
    else if (bus.rd_en && !bus.wr_en) next_state = bus.empty ? RD_ERROR : READ;
  end
endmodule
